// File: rtl/cp0_exc_sequencer.sv
// CP0 exception sequencer: owns Status/Cause/EPC, arbitrates sync exceptions vs latched IRQs,
// and sequences entry/eret with a one-cycle registered PC redirect.
module cp0_exc_sequencer #(
  parameter int unsigned N_IRQ      = 6,
  parameter logic [31:0] EXC_VECTOR = 32'h0040_0004,
  parameter logic [31:0] STATUS_RST = 32'h0000_0001
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             exc_req,
  input  logic [4:0]       exc_code,
  input  logic [N_IRQ-1:0] irq,
  input  logic             int_ok,
  input  logic             eret,
  input  logic             mtc0,
  input  logic [4:0]       addr,
  input  logic [31:0]      wdata,
  input  logic [31:0]      pc_in,
  output logic [31:0]      rdata,
  output logic             busy,
  output logic             redirect,
  output logic [31:0]      redirect_pc,
  output logic [31:0]      status_o,
  output logic [31:0]      epc_o
);

  typedef enum logic [1:0] {S_IDLE, S_ENTER, S_RET} state_t;

  state_t             state_q, state_d;
  logic [31:0]        status_q, status_d;
  logic [N_IRQ-1:0]   pend_q, pend_d;
  logic [4:0]         code_q, code_d;
  logic [31:0]        epc_q, epc_d;
  logic               redirect_q, redirect_d;
  logic               busy_q, busy_d;

  logic               is_idle;
  logic [4:0]         sync_code;
  logic               sync_masked;
  logic               sync_acc;
  logic               int_acc;
  logic               eret_do;
  logic               wr_do;
  logic [31:0]        cause_rd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      status_q   <= STATUS_RST;
      pend_q     <= '0;
      code_q     <= '0;
      epc_q      <= '0;
      redirect_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      status_q   <= status_d;
      pend_q     <= pend_d;
      code_q     <= code_d;
      epc_q      <= epc_d;
      redirect_q <= redirect_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    status_d    = status_q;
    pend_d      = pend_q;
    code_d      = code_q;
    epc_d       = epc_q;
    redirect_d  = 1'b0;
    busy_d      = 1'b0;
    is_idle     = (state_q == S_IDLE);
    sync_code   = 5'd13;
    sync_masked = status_q[10];

    // Unknown codes are folded onto trap, including its mask bit.
    case (exc_code)
      5'd8: begin
        sync_code   = 5'd8;
        sync_masked = status_q[8];
      end
      5'd9: begin
        sync_code   = 5'd9;
        sync_masked = status_q[9];
      end
      default: begin
        sync_code   = 5'd13;
        sync_masked = status_q[10];
      end
    endcase

    sync_acc = is_idle & exc_req & status_q[0] & ~sync_masked;
    int_acc  = is_idle & status_q[0] & int_ok & ~exc_req
             & (|(pend_q & status_q[16 +: N_IRQ]));
    eret_do  = is_idle & eret & ~sync_acc & ~int_acc;
    wr_do    = is_idle & mtc0 & ~sync_acc & ~int_acc & ~eret;

    if (sync_acc || int_acc) begin
      epc_d          = pc_in;
      code_d         = sync_acc ? sync_code : 5'd0;
      status_d[4:0]  = {status_q[3:0], 1'b0};
      state_d        = S_ENTER;
      redirect_d     = 1'b1;
      busy_d         = 1'b1;
    end else if (eret_do) begin
      status_d[4:0]  = {1'b0, status_q[4:1]};
      state_d        = S_RET;
      redirect_d     = 1'b1;
      busy_d         = 1'b1;
    end else if (wr_do) begin
      case (addr)
        5'd12:   status_d = wdata;
        5'd13:   pend_d   = wdata[8 +: N_IRQ];
        5'd14:   epc_d    = wdata;
        default: ;
      endcase
    end

    if (!is_idle) state_d = S_IDLE;

    // Interrupt set is applied last so it beats a same-cycle software clear.
    pend_d = pend_d | irq;
  end

  always_comb begin
    cause_rd             = '0;
    cause_rd[6:2]        = code_q;
    cause_rd[8 +: N_IRQ] = pend_q;
    case (addr)
      5'd12:   rdata = status_q;
      5'd13:   rdata = cause_rd;
      5'd14:   rdata = epc_q;
      default: rdata = '0;
    endcase
  end

  assign busy        = busy_q;
  assign redirect    = redirect_q;
  assign redirect_pc = (state_q == S_RET) ? epc_q : EXC_VECTOR;
  assign status_o    = status_q;
  assign epc_o       = epc_q;

endmodule

// File: tb/tb_cp0_exc_sequencer.sv
// Bench for cp0_exc_sequencer: directed scenarios plus a randomized run against a behavioural model.
module tb_cp0_exc_sequencer;

  localparam int          N   = 6;
  localparam logic [31:0] VEC = 32'h0040_0004;

  logic          clk = 1'b0;
  logic          rst;
  logic          exc_req;
  logic [4:0]    exc_code;
  logic [N-1:0]  irq;
  logic          int_ok;
  logic          eret;
  logic          mtc0;
  logic [4:0]    addr;
  logic [31:0]   wdata;
  logic [31:0]   pc_in;
  logic [31:0]   rdata;
  logic          busy;
  logic          redirect;
  logic [31:0]   redirect_pc;
  logic [31:0]   status_o;
  logic [31:0]   epc_o;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: architectural registers plus "a redirect pulse is due, to target".
  logic [31:0]   m_status;
  logic [N-1:0]  m_pend;
  logic [4:0]    m_code;
  logic [31:0]   m_epc;
  logic          m_pulse;
  logic [31:0]   m_target;

  cp0_exc_sequencer #(.N_IRQ(N), .EXC_VECTOR(VEC), .STATUS_RST(32'h0000_0001)) dut (
    .clk(clk), .rst(rst), .exc_req(exc_req), .exc_code(exc_code), .irq(irq),
    .int_ok(int_ok), .eret(eret), .mtc0(mtc0), .addr(addr), .wdata(wdata),
    .pc_in(pc_in), .rdata(rdata), .busy(busy), .redirect(redirect),
    .redirect_pc(redirect_pc), .status_o(status_o), .epc_o(epc_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    exc_req = 1'b0; exc_code = 5'd0; irq = '0; int_ok = 1'b0; eret = 1'b0;
    mtc0 = 1'b0; addr = 5'd0; wdata = 32'd0; pc_in = 32'd0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] a);
    logic [31:0] c;
    c = 32'd0;
    c[6:2] = m_code;
    c[8 +: N] = m_pend;
    if (a == 5'd12) return m_status;
    if (a == 5'd13) return c;
    if (a == 5'd14) return m_epc;
    return 32'd0;
  endfunction

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic m_step();
    int          ie;
    logic        masked;
    logic [4:0]  ncode;
    if (m_pulse) begin
      m_pulse = 1'b0;
    end else begin
      ncode  = (exc_code == 5'd8 || exc_code == 5'd9) ? exc_code : 5'd13;
      masked = (ncode == 5'd8) ? m_status[8] : (ncode == 5'd9) ? m_status[9] : m_status[10];
      ie     = int'(m_status[4:0]);
      if (exc_req && m_status[0] && !masked) begin
        m_epc = pc_in; m_code = ncode;
        m_status[4:0] = 5'((ie * 2) % 32);
        m_pulse = 1'b1; m_target = VEC;
      end else if (m_status[0] && int_ok && !exc_req && ((m_pend & m_status[16 +: N]) != 0)) begin
        m_epc = pc_in; m_code = 5'd0;
        m_status[4:0] = 5'((ie * 2) % 32);
        m_pulse = 1'b1; m_target = VEC;
      end else if (eret) begin
        m_status[4:0] = 5'(ie / 2);
        m_pulse = 1'b1; m_target = m_epc;
      end else if (mtc0) begin
        if (addr == 5'd12) m_status = wdata;
        else if (addr == 5'd13) m_pend = wdata[8 +: N];
        else if (addr == 5'd14) m_epc = wdata;
      end
    end
    m_pend = m_pend | irq;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    repeat (2) tick();
    addr = 5'd13; #1;
    n_checks++; if (status_o !== 32'h1) begin n_errors++; $display("FAIL reset_status got %h want 00000001", status_o); end
    n_checks++; if (epc_o !== 32'h0) begin n_errors++; $display("FAIL reset_epc got %h want 0", epc_o); end
    n_checks++; if (rdata !== 32'h0) begin n_errors++; $display("FAIL reset_cause got %h want 0", rdata); end
    n_checks++; if (busy !== 1'b0 || redirect !== 1'b0) begin n_errors++; $display("FAIL reset_busy_redir got %b%b want 00", busy, redirect); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_syscall();
    exc_req = 1'b1; exc_code = 5'd8; pc_in = 32'h0040_0100;
    tick();
    clear_inputs(); addr = 5'd13; #1;
    n_checks++; if (redirect !== 1'b1 || busy !== 1'b1) begin n_errors++; $display("FAIL sys_redirect got %b%b want 11", redirect, busy); end
    n_checks++; if (redirect_pc !== VEC) begin n_errors++; $display("FAIL sys_redirect_pc got %h want %h", redirect_pc, VEC); end
    n_checks++; if (epc_o !== 32'h0040_0100) begin n_errors++; $display("FAIL sys_epc got %h want 00400100", epc_o); end
    n_checks++; if (rdata[6:2] !== 5'd8) begin n_errors++; $display("FAIL sys_code got %0d want 8", rdata[6:2]); end
    n_checks++; if (status_o[4:0] !== 5'b00010) begin n_errors++; $display("FAIL sys_ie got %b want 00010", status_o[4:0]); end
    tick();
    n_checks++; if (redirect !== 1'b0 || busy !== 1'b0) begin n_errors++; $display("FAIL sys_idle got %b%b want 00", redirect, busy); end
  endtask

  task automatic test_eret();
    eret = 1'b1;
    tick();
    eret = 1'b0;
    n_checks++; if (redirect !== 1'b1 || redirect_pc !== 32'h0040_0100) begin n_errors++; $display("FAIL eret_pc got %b %h want 1 00400100", redirect, redirect_pc); end
    n_checks++; if (status_o[4:0] !== 5'b00001) begin n_errors++; $display("FAIL eret_ie got %b want 00001", status_o[4:0]); end
    tick();
    exc_req = 1'b1; exc_code = 5'd13; eret = 1'b1; pc_in = 32'h0040_0200;
    tick();
    clear_inputs();
    n_checks++; if (redirect !== 1'b1 || redirect_pc !== VEC) begin n_errors++; $display("FAIL trap_over_eret got %b %h want 1 %h", redirect, redirect_pc, VEC); end
    n_checks++; if (status_o[4:0] !== 5'b00010 || epc_o !== 32'h0040_0200) begin n_errors++; $display("FAIL trap_over_eret_regs got %b %h want 00010 00400200", status_o[4:0], epc_o); end
    tick();
    eret = 1'b1;
    tick();
    eret = 1'b0;
    tick();
  endtask

  task automatic test_mask();
    mtc0 = 1'b1; addr = 5'd12; wdata = 32'h0000_0101;
    tick();
    clear_inputs();
    n_checks++; if (status_o !== 32'h0000_0101) begin n_errors++; $display("FAIL mask_write got %h want 00000101", status_o); end
    exc_req = 1'b1; exc_code = 5'd8; pc_in = 32'h0040_0300;
    tick();
    clear_inputs();
    n_checks++; if (redirect !== 1'b0 || busy !== 1'b0) begin n_errors++; $display("FAIL mask_sys_taken got %b%b want 00", redirect, busy); end
    n_checks++; if (epc_o !== 32'h0040_0200 || status_o !== 32'h0000_0101) begin n_errors++; $display("FAIL mask_sys_regs got %h %h want 00400200 00000101", epc_o, status_o); end
    exc_req = 1'b1; exc_code = 5'd9; pc_in = 32'h0040_0304;
    tick();
    clear_inputs();
    n_checks++; if (redirect !== 1'b1 || status_o !== 32'h0000_0102 || epc_o !== 32'h0040_0304) begin n_errors++; $display("FAIL mask_break got %b %h %h want 1 00000102 00400304", redirect, status_o, epc_o); end
    tick();
    eret = 1'b1;
    tick();
    eret = 1'b0;
    tick();
  endtask

  task automatic test_irq();
    mtc0 = 1'b1; addr = 5'd12; wdata = 32'h0005_0001;
    tick();
    clear_inputs();
    irq = 6'b000101; int_ok = 1'b1; pc_in = 32'h0040_0400;
    tick();
    irq = '0;
    n_checks++; if (redirect !== 1'b0) begin n_errors++; $display("FAIL irq_early got %b want 0", redirect); end
    tick();
    int_ok = 1'b0; addr = 5'd13; #1;
    n_checks++; if (redirect !== 1'b1 || redirect_pc !== VEC || epc_o !== 32'h0040_0400) begin n_errors++; $display("FAIL irq_entry got %b %h %h want 1 %h 00400400", redirect, redirect_pc, epc_o, VEC); end
    n_checks++; if (rdata !== 32'h0000_0500) begin n_errors++; $display("FAIL irq_cause got %h want 00000500", rdata); end
    tick();
    eret = 1'b1;
    tick();
    eret = 1'b0;
    tick();
    mtc0 = 1'b1; addr = 5'd13; wdata = 32'd0;
    tick();
    mtc0 = 1'b0; #1;
    n_checks++; if (rdata[15:8] !== 8'h00) begin n_errors++; $display("FAIL irq_clear got %h want 00", rdata[15:8]); end
    irq = 6'b000100; pc_in = 32'h0040_0500;
    tick();
    irq = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (redirect !== 1'b0 || rdata[10] !== 1'b1) begin n_errors++; $display("FAIL irq_held got %b %b want 0 1", redirect, rdata[10]); end
    end
    int_ok = 1'b1;
    tick();
    int_ok = 1'b0;
    n_checks++; if (redirect !== 1'b1 || epc_o !== 32'h0040_0500) begin n_errors++; $display("FAIL irq_late got %b %h want 1 00400500", redirect, epc_o); end
    tick();
    eret = 1'b1;
    tick();
    eret = 1'b0;
    tick();
    mtc0 = 1'b1; addr = 5'd13; wdata = 32'd0;
    tick();
    clear_inputs();
  endtask

  task automatic test_pending_clear();
    mtc0 = 1'b1; addr = 5'd12; wdata = 32'h0000_0001;
    tick();
    irq = 6'b000001; addr = 5'd13; wdata = 32'd0;
    tick();
    irq = '0; mtc0 = 1'b0; #1;
    n_checks++; if (rdata[8] !== 1'b1) begin n_errors++; $display("FAIL pend_set_wins got %b want 1", rdata[8]); end
    mtc0 = 1'b1;
    tick();
    mtc0 = 1'b0; #1;
    n_checks++; if (rdata[8] !== 1'b0) begin n_errors++; $display("FAIL pend_cleared got %b want 0", rdata[8]); end
    exc_req = 1'b1; exc_code = 5'd8; pc_in = 32'h0040_0600;
    tick();
    clear_inputs();
    mtc0 = 1'b1; addr = 5'd14; wdata = 32'hDEAD_BEEF;
    tick();
    clear_inputs();
    n_checks++; if (epc_o !== 32'h0040_0600 || busy !== 1'b0) begin n_errors++; $display("FAIL mtc0_in_enter got %h %b want 00400600 0", epc_o, busy); end
    eret = 1'b1;
    tick();
    eret = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_enter();
    exc_req = 1'b1; exc_code = 5'd8; pc_in = 32'h0040_0700;
    tick();
    clear_inputs(); addr = 5'd13;
    n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL rst_pre_busy got %b want 1", busy); end
    #1 rst = 1'b1;
    #1;
    n_checks++; if (redirect !== 1'b0 || busy !== 1'b0) begin n_errors++; $display("FAIL rst_mid_outputs got %b%b want 00", redirect, busy); end
    n_checks++; if (status_o !== 32'h1 || epc_o !== 32'h0 || rdata !== 32'h0) begin n_errors++; $display("FAIL rst_mid_regs got %h %h %h want 00000001 0 0", status_o, epc_o, rdata); end
    #2 rst = 1'b0;
    tick();
  endtask

  task automatic test_random();
    logic [4:0] codes [4];
    logic [4:0] addrs [4];
    codes[0] = 5'd8; codes[1] = 5'd9; codes[2] = 5'd13; codes[3] = 5'd0;
    addrs[0] = 5'd12; addrs[1] = 5'd13; addrs[2] = 5'd14; addrs[3] = 5'd0;
    do_reset();
    m_status = 32'h1; m_pend = '0; m_code = '0; m_epc = '0; m_pulse = 1'b0; m_target = VEC;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      n_checks++; if (status_o !== m_status) begin n_errors++; $display("FAIL rnd_status cyc %0d got %h want %h", cyc, status_o, m_status); end
      n_checks++; if (epc_o !== m_epc) begin n_errors++; $display("FAIL rnd_epc cyc %0d got %h want %h", cyc, epc_o, m_epc); end
      n_checks++; if (busy !== m_pulse || redirect !== m_pulse) begin n_errors++; $display("FAIL rnd_pulse cyc %0d got %b%b want %b%b", cyc, busy, redirect, m_pulse, m_pulse); end
      if (m_pulse) begin
        n_checks++; if (redirect_pc !== m_target) begin n_errors++; $display("FAIL rnd_target cyc %0d got %h want %h", cyc, redirect_pc, m_target); end
      end
      exc_req  = ($urandom_range(0, 7) == 0);
      exc_code = ($urandom_range(0, 5) == 0) ? 5'($urandom) : codes[$urandom_range(0, 2)];
      irq      = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
      int_ok   = ($urandom_range(0, 2) != 0);
      eret     = ($urandom_range(0, 5) == 0);
      mtc0     = ($urandom_range(0, 4) == 0);
      addr     = ($urandom_range(0, 7) == 0) ? 5'($urandom) : addrs[$urandom_range(0, 3)];
      wdata    = $urandom;
      if (addr == 5'd12 && $urandom_range(0, 3) != 0) wdata[0] = 1'b1;
      if (addr == 5'd12) wdata[4:1] = 4'($urandom_range(0, 3));
      pc_in    = $urandom;
      #1;
      n_checks++; if (rdata !== m_read(addr)) begin n_errors++; $display("FAIL rnd_rdata cyc %0d addr %0d got %h want %h", cyc, addr, rdata, m_read(addr)); end
      m_step();
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_syscall();
    test_eret();
    test_mask();
    test_irq();
    test_pending_clear();
    test_reset_mid_enter();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
